// File: rtl/mem_access_unit.sv
// Load/store sequencer for a little-endian, 4-byte-wide data memory. Byte and half stores use read-modify-write.
// Latency after the accept edge: load or word store 2 cycles, byte/half store 3, illegal access 1. Req is ignored while Busy.
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        Store,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] RdData,
    output logic        MemRW,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] a_addr;
    logic [15:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_store;
    logic        a_uns;
    logic        err_q;
    logic [31:0] rd_data_q;
    logic [31:0] wdata_q;

    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        illegal;
    logic [31:0] ld_val;
    logic [31:0] merged;

    // The end address is computed one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        case (Size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr = {1'b0, Addr} + {30'd0, nbytes};
        illegal  = (Size == 2'b11)
                || (Size == 2'b01 && Addr[0])
                || (Size == 2'b10 && Addr[1:0] != 2'b00)
                || (end_addr > 33'(MEM_BYTES));
    end

    always_comb begin
        case (a_size)
            2'b00:   ld_val = a_uns ? {24'd0, MemRData[7:0]}
                                    : {{24{MemRData[7]}}, MemRData[7:0]};
            2'b01:   ld_val = a_uns ? {16'd0, MemRData[15:0]}
                                    : {{16{MemRData[15]}}, MemRData[15:0]};
            default: ld_val = MemRData;
        endcase
        if (a_size == 2'b00)
            merged = {MemRData[31:8], a_wdata[7:0]};
        else
            merged = {MemRData[31:16], a_wdata[15:0]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (illegal)
                        state_nx = FIN;
                    else if (Store && Size == 2'b10)
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = a_store ? WR : FIN;
            WR:      state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            a_addr    <= 32'd0;
            a_wdata   <= 16'd0;
            a_size    <= 2'b00;
            a_store   <= 1'b0;
            a_uns     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (Req) begin
                        a_addr  <= Addr;
                        a_wdata <= WrData[15:0];
                        a_size  <= Size;
                        a_store <= Store;
                        a_uns   <= Unsigned;
                        err_q   <= illegal;
                        if (!illegal && Store && Size == 2'b10)
                            wdata_q <= WrData;
                    end
                end
                RD: begin
                    if (a_store)
                        wdata_q <= merged;
                    else
                        rd_data_q <= ld_val;
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (state != IDLE);
    assign Done     = (state == FIN);
    assign MemRW    = (state == WR);
    assign Err      = err_q;
    assign RdData   = rd_data_q;
    assign MemAddr  = a_addr;
    assign MemWData = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1 KiB byte memory model that writes on the falling clock edge.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Req;
    logic        Store;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] RdData;
    logic        MemRW;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    logic [7:0] mem [0:1023];

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .CLK(CLK), .RST(RST), .Req(Req), .Store(Store), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .WrData(WrData), .Busy(Busy),
        .Done(Done), .Err(Err), .RdData(RdData), .MemRW(MemRW),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        MemRData = 32'd0;
        for (int k = 0; k < 4; k++)
            if (MemAddr + 32'(k) < 32'd1024)
                MemRData[8*k +: 8] = mem[10'(MemAddr + 32'(k))];
    end

    always @(negedge CLK) begin
        if (MemRW) begin
            pulses++;
            for (int k = 0; k < 4; k++)
                if (MemAddr + 32'(k) < 32'd1024)
                    mem[10'(MemAddr + 32'(k))] <= MemWData[8*k +: 8];
        end
    end

    function automatic logic [31:0] mword(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drives one request, scrambles the inputs after accept, and waits (bounded) for Done.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e);
        @(negedge CLK);
        Req = 1'b1; Store = st; Size = sz; Unsigned = un; Addr = a; WrData = wd;
        @(posedge CLK);
        @(negedge CLK);
        Req = 1'b0; Addr = 32'hFFFF_FFFF; WrData = 32'hDEAD_BEEF;
        chk("busy_after_accept", {31'd0, Busy}, 32'd1);
        lat = 0;
        e = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge CLK);
            if (Done) begin
                lat = i;
                e = Err;
                break;
            end
        end
    endtask

    int   lat;
    logic e;
    int   p0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        RST = 1'b1; Req = 1'b0; Store = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        Addr = 32'd0; WrData = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_busy",  {31'd0, Busy},  32'd0);
        chk("rst_done",  {31'd0, Done},  32'd0);
        chk("rst_err",   {31'd0, Err},   32'd0);
        chk("rst_rdata", RdData,         32'd0);
        chk("rst_memrw", {31'd0, MemRW}, 32'd0);
        chk("rst_maddr", MemAddr,        32'd0);
        chk("rst_mwdat", MemWData,       32'd0);

        // Word store then word load
        p0 = pulses;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, lat, e);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_err", {31'd0, e}, 32'd0);
        chk("sw_pulses", 32'(pulses - p0), 32'd1);
        chk("sw_mem", mword(32'h10), 32'h1234_5678);
        chk("sw_byte0", {24'd0, mem[32'h10]}, 32'h78);
        p0 = pulses;
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", RdData, 32'h1234_5678);
        chk("lw_pulses", 32'(pulses - p0), 32'd0);

        // Byte store via read-modify-write
        p0 = pulses;
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, lat, e);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_pulses", 32'(pulses - p0), 32'd1);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
        chk("lw_after_sb", RdData, 32'h1234_AB78);

        // Extension of byte and half loads
        run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, e);
        chk("lb", RdData, 32'hFFFF_FFAB);
        run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e);
        chk("lbu", RdData, 32'h0000_00AB);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e);
        chk("lh_pos", RdData, 32'h0000_1234);
        run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, e);
        chk("lh_neg", RdData, 32'hFFFF_AB78);
        run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, e);
        chk("lhu", RdData, 32'h0000_AB78);

        // Half store keeps the other half of the word
        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_8001, lat, e);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_mem", mword(32'h10), 32'h8001_AB78);
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e);
        chk("lh_after_sh", RdData, 32'hFFFF_8001);

        // Illegal accesses: misaligned, out of range, bad size, address wrap
        p0 = pulses;
        run_op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_5555, lat, e);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_err", {31'd0, e}, 32'd1);
        run_op(1'b0, 2'b10, 1'b0, 32'h3FD, 32'h0, lat, e);
        chk("lw_oor_lat", 32'(lat), 32'd1);
        chk("lw_oor_err", {31'd0, e}, 32'd1);
        run_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e);
        chk("size11_err", {31'd0, e}, 32'd1);
        run_op(1'b1, 2'b00, 1'b0, 32'h400, 32'h0000_0077, lat, e);
        chk("sb_oor_err", {31'd0, e}, 32'd1);
        run_op(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, lat, e);
        chk("lb_wrap_err", {31'd0, e}, 32'd1);
        chk("illegal_pulses", 32'(pulses - p0), 32'd0);
        chk("illegal_rdata", RdData, 32'hFFFF_8001);
        chk("illegal_mem", mword(32'h10), 32'h8001_AB78);

        // Last legal bytes of memory; Err clears on the next accept
        run_op(1'b1, 2'b00, 1'b0, 32'h3FF, 32'h0000_0080, lat, e);
        chk("sb_top_err", {31'd0, e}, 32'd0);
        chk("sb_top_lat", 32'(lat), 32'd3);
        run_op(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, lat, e);
        chk("lb_top", RdData, 32'hFFFF_FF80);
        run_op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, e);
        chk("lw_top_err", {31'd0, e}, 32'd0);
        chk("lw_top", RdData, 32'h8000_0000);

        // Reset while a byte store is in its read cycle
        run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_BABE, lat, e);
        p0 = pulses;
        @(negedge CLK);
        Req = 1'b1; Store = 1'b1; Size = 2'b00; Addr = 32'h20; WrData = 32'h55;
        @(posedge CLK);
        @(negedge CLK);
        Req = 1'b0;
        chk("rst_rd_busy_pre", {31'd0, Busy}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_rd_busy", {31'd0, Busy}, 32'd0);
        chk("rst_rd_done", {31'd0, Done}, 32'd0);
        chk("rst_rd_maddr", MemAddr, 32'd0);
        chk("rst_rd_rdata", RdData, 32'd0);
        @(negedge CLK);
        chk("rst_rd_pulses", 32'(pulses - p0), 32'd0);
        chk("rst_rd_mem", mword(32'h20), 32'hCAFE_BABE);

        // Req held high: one access per accept, re-accept only after FIN
        p0 = pulses;
        Req = 1'b1; Store = 1'b1; Size = 2'b10; Unsigned = 1'b0;
        Addr = 32'h30; WrData = 32'h1111_1111;
        @(posedge CLK);
        @(negedge CLK);
        WrData = 32'h2222_2222;
        chk("held_wr", {31'd0, MemRW}, 32'd1);
        @(negedge CLK);
        chk("held_done", {31'd0, Done}, 32'd1);
        @(negedge CLK);
        chk("held_idle", {31'd0, Busy}, 32'd0);
        chk("held_one_pulse", 32'(pulses - p0), 32'd1);
        chk("held_mem1", mword(32'h30), 32'h1111_1111);
        @(negedge CLK);
        chk("held_reaccept", {31'd0, Busy}, 32'd1);
        Req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (Done) begin
                lat = i;
                break;
            end
        end
        chk("held_second_done", 32'(lat), 32'd1);
        @(negedge CLK);
        chk("held_two_pulses", 32'(pulses - p0), 32'd2);
        chk("held_mem2", mword(32'h30), 32'h2222_2222);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
